// File: rtl/fp_div_seq_n32_if.sv
// Handshake and data bundle between the sequential FP divider and its neighbours.
// The master drives operands and accepts results; the slave is the divider.
interface fp_div_seq_n32_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] y;
  logic         flag_dz;
  logic         flag_ovf;
  logic         flag_unf;
  logic         flag_inv;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, y, flag_dz, flag_ovf, flag_unf, flag_inv
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, y, flag_dz, flag_ovf, flag_unf, flag_inv
  );
endinterface

// File: rtl/fp_div_seq_n32.sv
// Iterative IEEE 754 single-precision divider: radix-2 restoring mantissa
// division (one quotient bit per cycle) followed by round-to-nearest-even.
module fp_div_seq_n32 #(
  parameter int N    = 32,
  parameter int E    = 8,
  parameter int M    = 23,
  parameter int BIAS = 127
) (
  input  logic           clk,
  input  logic           rst_n,
  fp_div_seq_n32_if.slave bus
);
  localparam logic [N-1:0] QNAN = 32'h7FC00000;
  localparam logic [E-1:0] EMAX = '1;

  typedef enum logic [1:0] {IDLE, DIV, RND, DONE} state_t;

  state_t       state;
  logic [4:0]   cnt;
  logic [M+1:0] rem;
  logic [M+1:0] d;
  logic [M+2:0] q;
  logic         sign;
  logic [E-1:0] ea;
  logic [E-1:0] eb;
  logic [N-1:0] y_reg;
  logic         dz_reg;
  logic         ovf_reg;
  logic         unf_reg;
  logic         inv_reg;
  logic         in_ready_reg;
  logic         out_valid_reg;

  logic         a_zero, a_inf, a_nan;
  logic         b_zero, b_inf, b_nan;
  logic         sign_in;
  logic         special;
  logic         special_dz;
  logic         special_inv;
  logic [N-1:0] special_y;

  logic               ge;
  logic [M+1:0]       rem_next;
  logic [M-1:0]       mant_t;
  logic               g_bit;
  logic               s_bit;
  logic [M:0]         mant_sum;
  logic signed [9:0]  e_t;
  logic signed [9:0]  e_fin;

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.y         = y_reg;
  assign bus.flag_dz   = dz_reg;
  assign bus.flag_ovf  = ovf_reg;
  assign bus.flag_unf  = unf_reg;
  assign bus.flag_inv  = inv_reg;

  // Operand classification; denormals are treated as zero.
  always_comb begin
    a_zero      = (bus.a[N-2:M] == '0);
    a_inf       = (bus.a[N-2:M] == EMAX) && (bus.a[M-1:0] == '0);
    a_nan       = (bus.a[N-2:M] == EMAX) && (bus.a[M-1:0] != '0);
    b_zero      = (bus.b[N-2:M] == '0);
    b_inf       = (bus.b[N-2:M] == EMAX) && (bus.b[M-1:0] == '0);
    b_nan       = (bus.b[N-2:M] == EMAX) && (bus.b[M-1:0] != '0);
    sign_in     = bus.a[N-1] ^ bus.b[N-1];
    special     = 1'b1;
    special_dz  = 1'b0;
    special_inv = 1'b0;
    special_y   = QNAN;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      special_inv = 1'b1;
    end else if (a_inf) begin
      special_y = {sign_in, EMAX, {M{1'b0}}};
    end else if (b_inf || a_zero) begin
      special_y = {sign_in, {(N-1){1'b0}}};
    end else if (b_zero) begin
      special_y  = {sign_in, EMAX, {M{1'b0}}};
      special_dz = 1'b1;
    end else begin
      special = 1'b0;
    end
  end

  // One restoring step, plus normalisation and rounding of the finished quotient.
  always_comb begin
    ge       = (rem >= d);
    rem_next = ge ? (rem - d) : rem;
    if (q[M+2]) begin
      mant_t = q[M+1:2];
      g_bit  = q[1];
      s_bit  = q[0] | (rem != '0);
      e_t    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + $signed(10'(BIAS));
    end else begin
      mant_t = q[M:1];
      g_bit  = q[0];
      s_bit  = (rem != '0);
      e_t    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + $signed(10'(BIAS - 1));
    end
    mant_sum = {1'b0, mant_t} + {{M{1'b0}}, (g_bit & (s_bit | mant_t[0]))};
    e_fin    = e_t + $signed({9'd0, mant_sum[M]});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      rem           <= '0;
      d             <= '0;
      q             <= '0;
      sign          <= 1'b0;
      ea            <= '0;
      eb            <= '0;
      y_reg         <= '0;
      dz_reg        <= 1'b0;
      ovf_reg       <= 1'b0;
      unf_reg       <= 1'b0;
      inv_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sign         <= sign_in;
            ea           <= bus.a[N-2:M];
            eb           <= bus.b[N-2:M];
            in_ready_reg <= 1'b0;
            dz_reg       <= 1'b0;
            ovf_reg      <= 1'b0;
            unf_reg      <= 1'b0;
            inv_reg      <= 1'b0;
            if (special) begin
              y_reg         <= special_y;
              dz_reg        <= special_dz;
              inv_reg       <= special_inv;
              out_valid_reg <= 1'b1;
              state         <= DONE;
            end else begin
              rem   <= {2'b01, bus.a[M-1:0]};
              d     <= {2'b01, bus.b[M-1:0]};
              q     <= '0;
              cnt   <= '0;
              state <= DIV;
            end
          end
        end
        DIV: begin
          q   <= {q[M+1:0], ge};
          rem <= rem_next << 1;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd25) begin
            state <= RND;
          end
        end
        RND: begin
          if (e_fin >= 10'sd255) begin
            y_reg   <= {sign, EMAX, {M{1'b0}}};
            ovf_reg <= 1'b1;
          end else if (e_fin <= 10'sd0) begin
            y_reg   <= {sign, {(N-1){1'b0}}};
            unf_reg <= 1'b1;
          end else begin
            y_reg <= {sign, e_fin[E-1:0], mant_sum[M-1:0]};
          end
          out_valid_reg <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          // Handshake completes here; a new accept waits for the IDLE bubble.
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fp_div_seq_n32.md
Name: fp_div_seq_n32

Overview:
- Iterative IEEE 754 single-precision divider, y = a / b; the inverse operation of the team's combinational FP multiplier.
- Uses a radix-2 restoring mantissa divider, one quotient bit per cycle, followed by round-to-nearest-even.
- Sits behind valid/ready handshakes on input and output so it can sit in a streaming FP datapath.

Parameters:
- N, 32, total word width
- E, 8, exponent field width
- M, 23, stored mantissa width
- BIAS, 127, exponent bias
- Only the default set is supported and verified.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands a and b are valid
- in_ready  out  1  divider can accept operands (high only in IDLE)
- a  in  32  dividend, IEEE 754
- b  in  32  divisor, IEEE 754
- out_valid  out  1  y and flags are valid
- out_ready  in  1  consumer accepts result
- y  out  32  quotient, IEEE 754
- flag_dz  out  1  divide by zero
- flag_ovf  out  1  overflow
- flag_unf  out  1  underflow
- flag_inv  out  1  invalid operation

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, y=0, all flags=0. Deasserting rst_n mid-operation discards any in-flight division.
- States are IDLE -> DIV -> RND -> DONE -> IDLE.
- Acceptance: operands are accepted on a rising edge where in_valid && in_ready. At that edge a, b, sign = a[31]^b[31] and exponents are registered.
- Operand classes:
  - Exponent field 0 means zero; denormals are flushed to zero.
  - Exponent field 255 with mantissa 0 means inf.
  - Exponent field 255 with mantissa != 0 means NaN.
- Special cases: the accepting edge goes straight to DONE, so out_valid is high 1 cycle after acceptance.
  - Either operand NaN, 0/0, or inf/inf -> y=0x7FC00000, flag_inv=1.
  - a inf -> signed inf.
  - b inf -> signed zero.
  - a zero -> signed zero.
  - b zero with a finite nonzero -> signed inf, flag_dz=1.
- Normal case, DIV state:
  - Initialise rem = {1,a[22:0]} (25-bit) and d = {1,b[22:0]}.
  - Each cycle: q = {q[24:0], rem>=d}; rem = (rem>=d ? rem-d : rem) << 1.
  - A 5-bit counter runs for exactly 26 cycles, giving q[25:0].
- RND state (1 cycle):
  - If q[25]=1: mant = q[24:2], G = q[1], S = q[0] | (rem!=0), e = ea - eb + 127.
  - Else: mant = q[23:1], G = q[0], S = (rem!=0), e = ea - eb + 126.
  - Round up when G && (S || mant[0]). If mant wraps from all ones to 0, e increments.
  - e is computed in 10-bit signed arithmetic.
  - e >= 255 -> signed inf, flag_ovf=1.
  - e <= 0 -> signed zero, flag_unf=1.
  - Otherwise y = {sign, e[7:0], mant}.
- Latency, normal path: out_valid is high 28 cycles after the accepting edge (26 DIV + 1 RND + register).
- DONE state:
  - out_valid=1; y and flags are held stable until out_ready=1.
  - On the edge where out_valid && out_ready, the block returns to IDLE, out_valid=0, and in_ready=1 from the next cycle.
  - There is no same-cycle accept while in DONE; one bubble cycle is mandatory.
- in_valid outside IDLE is ignored, and a/b changes outside the accepting edge have no effect.
- Flags are cleared when a new operation is accepted.
- Throughput: one division per 29 cycles minimum when out_ready is tied high.

Test Plan:
- 6.0/2.0: a=0x40C00000, b=0x40000000 -> y=0x40400000, all flags 0, out_valid exactly 28 cycles after accept.
- 1.0/3.0: a=0x3F800000, b=0x40400000 -> y=0x3EAAAAAB (rounding up); -1.0/3.0 -> 0xBEAAAAAB.
- Specials, each 1-cycle latency:
  - 1.0/0 -> 0x7F800000, flag_dz=1.
  - 0/0 -> 0x7FC00000, flag_inv=1.
  - 0x7F800000/0x7F800000 -> 0x7FC00000, flag_inv=1.
  - 0x7FC00001/1.0 -> 0x7FC00000, flag_inv=1.
- Range limits:
  - 0x7F000000/0x3E800000 -> 0x7F800000, flag_ovf=1.
  - 0x00800000/0x40000000 -> 0x00000000, flag_unf=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> y, flags and out_valid stay stable and in_ready stays 0; a second in_valid pulse is ignored; after out_ready=1 the block returns to IDLE and accepts the next operands.
- Reset mid-operation: drop rst_n 10 cycles into DIV -> out_valid=0 and in_ready=1 immediately (asynchronously); the next division 2.0/4.0 returns 0x3F000000.
